// File: rtl/dvi_pkg.sv
// Shared types and constants for the DVI/VGA test-pattern raster source.
package dvi_pkg;

    typedef enum logic [1:0] {
        MODE_BARS  = 2'd0,
        MODE_CHECK = 2'd1,
        MODE_RAMP  = 2'd2,
        MODE_FCNT  = 2'd3
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Per-bar {r,g,b} channel enables: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [2:0] BAR_RGB [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                           3'b101, 3'b100, 3'b001, 3'b000};

    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        return BAR_RGB[idx];
    endfunction

endpackage

// File: rtl/dvi_timing.sv
// Raster counters, start/stop run control, raw sync/de generation and end-of-frame detection.
module dvi_timing
    import dvi_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned HW       = $clog2(H_TOTAL),
    localparam int unsigned VW       = $clog2(V_TOTAL)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          stop_i,
    output logic [HW-1:0] h_o,
    output logic [VW-1:0] v_o,
    output logic          run_o,
    output logic          de_raw_o,
    output logic          hs_raw_o,
    output logic          vs_raw_o,
    output logic          eof_o
);

    state_e        state_q;
    logic [HW-1:0] h_q;
    logic [VW-1:0] v_q;
    logic          stop_pend_q;
    logic          h_last, v_last, stop_now, hs_act, vs_act;

    assign h_last   = (h_q == HW'(H_TOTAL - 1));
    assign v_last   = (v_q == VW'(V_TOTAL - 1));
    assign run_o    = (state_q == RUN);
    assign eof_o    = run_o && h_last && v_last;
    assign stop_now = stop_pend_q | stop_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            h_q         <= '0;
            v_q         <= '0;
            stop_pend_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    h_q         <= '0;
                    v_q         <= '0;
                    stop_pend_q <= 1'b0;
                    if (start_i) state_q <= RUN;
                end
                RUN: begin
                    if (eof_o && stop_now) begin
                        state_q     <= IDLE;
                        stop_pend_q <= 1'b0;
                        h_q         <= '0;
                        v_q         <= '0;
                    end else begin
                        stop_pend_q <= stop_now;
                        h_q         <= h_last ? '0 : h_q + 1'b1;
                        if (h_last) v_q <= v_last ? '0 : v_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign hs_act = run_o && (32'(h_q) >= H_ACTIVE + H_FP)
                          && (32'(h_q) <  H_ACTIVE + H_FP + H_SYNC);
    assign vs_act = run_o && (32'(v_q) >= V_ACTIVE + V_FP)
                          && (32'(v_q) <  V_ACTIVE + V_FP + V_SYNC);

    assign h_o      = h_q;
    assign v_o      = v_q;
    assign de_raw_o = run_o && (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);
    assign hs_raw_o = hs_act ? HSYNC_POL : ~HSYNC_POL;
    assign vs_raw_o = vs_act ? VSYNC_POL : ~VSYNC_POL;

endmodule

// File: rtl/dvi_pattern_gen.sv
// DVI/VGA raster source: pattern mux, frame counter and registered video outputs.
module dvi_pattern_gen
    import dvi_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    parameter int unsigned CW        = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          stop_i,
    input  logic [1:0]    mode_i,
    output logic [CW-1:0] red_o,
    output logic [CW-1:0] green_o,
    output logic [CW-1:0] blue_o,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          de_o,
    output logic          busy_o,
    output logic          frame_done_o,
    output logic [15:0]   frame_count_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned BAR_W   = H_ACTIVE / 8;
    localparam int unsigned BCW     = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    logic [HW-1:0]  h;
    logic [VW-1:0]  v;
    logic           run, de_raw, hs_raw, vs_raw, eof, h_last;
    mode_e          mode_q, mode_eff;
    logic [BCW-1:0] bar_cnt_q;
    logic [2:0]     bar_idx_q;
    logic [2:0]     rgb;
    logic [CW-1:0]  pr, pg, pb;
    logic [CW-1:0]  red_q, green_q, blue_q;
    logic           hsync_q, vsync_q, de_q, busy_q, frame_done_q;
    logic [15:0]    frame_count_q;

    dvi_timing #(
        .H_ACTIVE  (H_ACTIVE),
        .H_FP      (H_FP),
        .H_SYNC    (H_SYNC),
        .H_BP      (H_BP),
        .V_ACTIVE  (V_ACTIVE),
        .V_FP      (V_FP),
        .V_SYNC    (V_SYNC),
        .V_BP      (V_BP),
        .HSYNC_POL (HSYNC_POL),
        .VSYNC_POL (VSYNC_POL)
    ) u_timing (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .stop_i   (stop_i),
        .h_o      (h),
        .v_o      (v),
        .run_o    (run),
        .de_raw_o (de_raw),
        .hs_raw_o (hs_raw),
        .vs_raw_o (vs_raw),
        .eof_o    (eof)
    );

    assign h_last = (h == HW'(H_TOTAL - 1));

    // The origin pixel already uses the freshly sampled mode.
    assign mode_eff = (h == '0 && v == '0) ? mode_e'(mode_i) : mode_q;

    // Bar sub-counter tracks h so the bar index needs no divider.
    always_ff @(posedge clk_i) begin
        if (rst_i || !run || h_last) begin
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
        end else if (bar_cnt_q == BCW'(BAR_W - 1)) begin
            bar_cnt_q <= '0;
            bar_idx_q <= bar_idx_q + 3'd1;
        end else begin
            bar_cnt_q <= bar_cnt_q + 1'b1;
        end
    end

    always_comb begin
        rgb = bar_rgb(bar_idx_q);
        pr  = '0;
        pg  = '0;
        pb  = '0;
        unique case (mode_eff)
            MODE_BARS: begin
                pr = {CW{rgb[2]}};
                pg = {CW{rgb[1]}};
                pb = {CW{rgb[0]}};
            end
            MODE_CHECK: begin
                if (((32'(h) ^ 32'(v)) & 32'd8) != 32'd0) begin
                    pr = '1;
                    pg = '1;
                    pb = '1;
                end
            end
            MODE_RAMP: begin
                pr = CW'(h);
                pg = CW'(h);
                pb = CW'(h);
            end
            MODE_FCNT: begin
                pr = CW'(frame_count_q);
                pb = ~CW'(frame_count_q);
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q        <= MODE_BARS;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            de_q          <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            mode_q       <= mode_eff;
            red_q        <= de_raw ? pr : '0;
            green_q      <= de_raw ? pg : '0;
            blue_q       <= de_raw ? pb : '0;
            hsync_q      <= hs_raw;
            vsync_q      <= vs_raw;
            de_q         <= de_raw;
            busy_q       <= run;
            frame_done_q <= eof;
            if (eof) frame_count_q <= frame_count_q + 16'd1;
        end
    end

    assign red_o         = red_q;
    assign green_o       = green_q;
    assign blue_o        = blue_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign de_o          = de_q;
    assign busy_o        = busy_q;
    assign frame_done_o  = frame_done_q;
    assign frame_count_o = frame_count_q;

endmodule

// File: doc/dvi_pattern_gen.md
# dvi_pattern_gen

Parametrised DVI/VGA raster source for bring-up of the video output path. It produces full timing: active area, front porch, sync and back porch, with programmable sync polarity. It selects one of four test patterns, runs continuously until told to stop, and counts frames. It sits in the same place as the earlier fixed-size stimulus block, directly feeding the DVI encoder's RGB/hsync/vsync/de inputs.

## Interface
- H_ACTIVE, 640: active pixels per line; must be a multiple of 8
- H_FP, 16: horizontal front porch, in pixels
- H_SYNC, 96: hsync width, in pixels
- H_BP, 48: horizontal back porch, in pixels
- V_ACTIVE, 480: active lines per frame
- V_FP, 10: vertical front porch, in lines
- V_SYNC, 2: vsync width, in lines
- V_BP, 33: vertical back porch, in lines
- HSYNC_POL, 0: asserted level of hsync
- VSYNC_POL, 0: asserted level of vsync
- CW, 8: bits per colour channel

Ports:
- clock  in  1  pixel clock
- reset  in  1  synchronous, active-high
- start  in  1  begin raster; honoured only in IDLE
- stop  in  1  request end of run after the current frame completes; sticky until honoured
- mode  in  2  pattern select: 0 colour bars, 1 checkerboard, 2 grey ramp, 3 frame-count fill
- red, green, blue  out  CW each  pixel colour
- hsync, vsync  out  1 each  sync outputs, asserted at the *_POL level
- de  out  1  data enable; high only in the active area
- busy  out  1  high while in RUN
- frame_done  out  1  one-cycle pulse
- frame_count  out  16  count of completed frames; wraps at 2^16

## Operation
- Totals are fixed: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- h counter runs 0..H_TOTAL-1 and the v counter runs 0..V_TOTAL-1. Each line is laid out as active, then FP, then sync, then BP.
- hsync is asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- vsync is asserted for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), over whole lines.
- de = (h < H_ACTIVE) && (v < V_ACTIVE). Colours are 0 whenever de is 0.
- State machine:
  - IDLE: counters are held at 0 and all outputs are inactive. start → RUN.
  - RUN: counters advance every cycle. If stop is pending when h=H_TOTAL-1 and v=V_TOTAL-1, go to IDLE. Otherwise wrap to (0,0) and continue.
- mode is sampled into a register at (0,0) of every frame. A mid-frame change takes effect at the next frame only.
- Patterns, where full = all ones and x,y are the h,v counters:
  - 0 colour bars: 8 bars, each H_ACTIVE/8 wide, in the order white, yellow, cyan, green, magenta, red, blue, black. The bar index comes from a bar-width sub-counter; no divider.
  - 1 checkerboard: white when x[3]^y[3] is set, black otherwise.
  - 2 grey ramp: r=g=b=x[CW-1:0], truncated.
  - 3 frame-count fill: red=frame_count[CW-1:0], green=0, blue=~frame_count[CW-1:0].
- stop asserted in IDLE, or together with start, is discarded. start asserted in RUN is ignored.
- At the end-of-frame pixel, frame_count increments by 1, from 0xFFFF wrapping to 0.

## Timing
- All outputs are registered and lag the counters by 1 cycle.
- start is sampled at edge k. Counters hold (0,0) after edge k. The first active pixel (0,0) appears on outputs after edge k+1, with busy=1 from edge k+1.
- frame_done pulses in the output cycle of pixel (H_TOTAL-1, V_TOTAL-1). frame_count updates in the same cycle.
- After the final frame, busy=0 and outputs go inactive in the cycle after frame_done.
- Reset values: state IDLE, counters 0, red/green/blue=0, de=0, busy=0, frame_done=0, frame_count=0, pending stop cleared.
  - hsync=~HSYNC_POL and vsync=~VSYNC_POL.
  - Reset mid-frame takes effect at the next edge, with no partial-frame completion.

## Structure
- Package dvi_pkg holds:
  - the mode enum (MODE_BARS, MODE_CHECK, MODE_RAMP, MODE_FCNT)
  - the state enum (IDLE, RUN)
  - the 8-entry colour-bar constant list
- Sub-module dvi_timing holds the counters, the stop/start FSM, sync/de generation and end-of-frame detection. It exports h, v, de_raw, hs_raw, vs_raw and eof.
- The top level holds the pattern mux, frame counter and output registers.

## Test plan
Use a small configuration: H 16/2/3/3 (H_TOTAL=24), V 4/1/2/1 (V_TOTAL=8), polarities 0.
- Reset, then a 1-cycle start with mode=0:
  - busy=1 one cycle later
  - de is high for 16 consecutive cycles per line, then low for 8
  - hsync is low for exactly 3 cycles, starting 18 cycles after de rises
- Colour bars: each bar lasts 2 pixels. The line reads white,white,yellow,yellow,…,black,black, i.e. r/g/b = FF/FF/FF, then FF/FF/00, and so on.
- vsync is low over lines 5–6, i.e. 48 cycles. The low period starts at the first pixel of line 5.
- mode=1 from the start:
  - pixels 0–7 of line 0 are black, pixels 8–15 white
  - mode switches to 2 mid-frame; the ramp 00..0F first appears on the next frame
- Three frames, then stop asserted mid frame 4:
  - frame_done pulses 4 times, 192 cycles apart
  - frame_count reaches 4
  - busy falls the cycle after the last pulse
  - syncs are inactive (1) afterward
- Reset mid-line, then start again: outputs are inactive the cycle after reset, and the first pixel after restart is (0,0).
- Force frame_count to 0xFFFF (or run 65536 frames in a fast config): it wraps to 0, and mode 3 shows red=00, blue=FF.
